// File: rtl/lcd_clock_mux.sv
// HD44780 4-bit driver: power-up init, per-frame snapshot of NUM_CH "MM:SS" clocks, nibble streaming.
// Define LCD_ACTIVE_MARK_EN to add the active input and a '*'/' ' marker before each clock.
`timescale 1ns/1ps
module lcd_clock_mux #(
   parameter int NUM_CH        = 2,
   parameter int TIME_W        = 6,
   parameter int DIV           = 50000,
   parameter int PWRUP_TICKS   = 20,
   parameter int REFRESH_TICKS = 100
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_CH*TIME_W-1:0] min_flat,
   input  logic [NUM_CH*TIME_W-1:0] seg_flat,
`ifdef LCD_ACTIVE_MARK_EN
   input  logic [NUM_CH-1:0]        active,
`endif
   output logic [5:0]               lcd,
   output logic                     busy,
   output logic                     frame_done
);

   localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int CNT_MAX = (PWRUP_TICKS > REFRESH_TICKS) ? PWRUP_TICKS : REFRESH_TICKS;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
`ifdef LCD_ACTIVE_MARK_EN
   localparam int CHARS = 6;
`else
   localparam int CHARS = 5;
`endif

   typedef enum logic [2:0] {PWRUP, INIT, IDLE, SNAP, ADDR, CHAR, DONE} state_t;

   state_t                    r_state, w_state_nxt;
   logic [DIV_W-1:0]          r_div;
   logic [CNT_W-1:0]          r_cnt, w_cnt_nxt;
   logic [3:0]                r_idx, w_idx_nxt;
   logic [1:0]                r_phase, w_phase_nxt;
   logic                      r_half, w_half_nxt;
   logic [1:0]                r_ch, w_ch_nxt;
   logic [NUM_CH*TIME_W-1:0]  r_min, r_seg;
   logic [4:0]                r_last;
   logic                      w_tick, w_xfer, w_rs, w_last_ph;
   logic [3:0]                w_nib, w_init_nib, w_pos;
   logic [7:0]                w_byte, w_char, w_min_d, w_seg_d;
   logic [TIME_W-1:0]         w_min_v, w_seg_v;
`ifdef LCD_ACTIVE_MARK_EN
   logic [NUM_CH-1:0]         r_act;
   logic                      w_act;
`endif

   // Binary to {tens, ones} by repeated compare/subtract; 6 steps cover 0..63.
   function automatic logic [7:0] f_bcd(input logic [TIME_W-1:0] v);
      logic [7:0] rem;
      logic [3:0] t;
      rem = 8'(v);
      t   = 4'd0;
      for (int i = 0; i < 6; i++) begin
         if (rem >= 8'd10) begin
            rem = rem - 8'd10;
            t   = t + 4'd1;
         end
      end
      return {t, rem[3:0]};
   endfunction

   assign w_tick    = (r_div == DIV_W'(DIV - 1));
   assign w_last_ph = (r_phase == 2'd2);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)         r_div <= '0;
      else if (w_tick) r_div <= '0;
      else             r_div <= r_div + 1'b1;
   end

   always_comb begin
      w_min_v = '0;
      w_seg_v = '0;
`ifdef LCD_ACTIVE_MARK_EN
      w_act   = 1'b0;
`endif
      for (int k = 0; k < NUM_CH; k++) begin
         if (r_ch == 2'(k)) begin
            w_min_v = r_min[k*TIME_W +: TIME_W];
            w_seg_v = r_seg[k*TIME_W +: TIME_W];
`ifdef LCD_ACTIVE_MARK_EN
            w_act   = r_act[k];
`endif
         end
      end
   end

   assign w_min_d = f_bcd(w_min_v);
   assign w_seg_d = f_bcd(w_seg_v);

   always_comb begin
      w_char = 8'h3A;
      w_pos  = r_idx;
`ifdef LCD_ACTIVE_MARK_EN
      w_pos  = r_idx - 4'd1;
`endif
      case (w_pos)
         4'd0:    w_char = {4'h3, w_min_d[7:4]};
         4'd1:    w_char = {4'h3, w_min_d[3:0]};
         4'd3:    w_char = {4'h3, w_seg_d[7:4]};
         4'd4:    w_char = {4'h3, w_seg_d[3:0]};
         default: w_char = 8'h3A;
      endcase
`ifdef LCD_ACTIVE_MARK_EN
      if (r_idx == 4'd0) w_char = w_act ? 8'h2A : 8'h20;
`endif
   end

   always_comb begin
      case (r_idx)
         4'd0, 4'd1, 4'd2: w_init_nib = 4'h3;
         4'd3, 4'd4:       w_init_nib = 4'h2;
         4'd5:             w_init_nib = 4'h8;
         4'd7:             w_init_nib = 4'hC;
         4'd9:             w_init_nib = 4'h6;
         4'd11:            w_init_nib = 4'h1;
         default:          w_init_nib = 4'h0;
      endcase
   end

   // Nibble currently on the bus; outside transfers the bus replays r_last with E low.
   always_comb begin
      w_xfer = 1'b0;
      w_rs   = 1'b0;
      w_byte = 8'h00;
      w_nib  = 4'h0;
      case (r_state)
         INIT: begin
            w_xfer = (r_idx < 4'd12);
            w_nib  = w_init_nib;
         end
         ADDR: begin
            w_xfer = 1'b1;
            w_byte = {1'b1, r_ch[0], 2'b00, r_ch[1], 3'b000};
            w_nib  = r_half ? w_byte[3:0] : w_byte[7:4];
         end
         CHAR: begin
            w_xfer = 1'b1;
            w_rs   = 1'b1;
            w_byte = w_char;
            w_nib  = r_half ? w_byte[3:0] : w_byte[7:4];
         end
         default: ;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_idx_nxt   = r_idx;
      w_phase_nxt = r_phase;
      w_half_nxt  = r_half;
      w_ch_nxt    = r_ch;
      case (r_state)
         PWRUP: if (w_tick) begin
            if (r_cnt == CNT_W'(PWRUP_TICKS - 1)) begin
               w_state_nxt = INIT;
               w_cnt_nxt   = '0;
               w_idx_nxt   = 4'd0;
               w_phase_nxt = 2'd0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         INIT: if (w_tick) begin
            if (r_idx < 4'd12) begin
               w_phase_nxt = w_last_ph ? 2'd0 : r_phase + 2'd1;
               if (w_last_ph) w_idx_nxt = r_idx + 4'd1;
            end else if (r_idx == 4'd13) begin
               w_state_nxt = SNAP;
               w_idx_nxt   = 4'd0;
            end else begin
               w_idx_nxt = r_idx + 4'd1;
            end
         end
         IDLE: if (w_tick) begin
            if (r_cnt == CNT_W'(REFRESH_TICKS - 1)) begin
               w_state_nxt = SNAP;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         SNAP: begin
            w_state_nxt = ADDR;
            w_ch_nxt    = 2'd0;
            w_idx_nxt   = 4'd0;
            w_phase_nxt = 2'd0;
            w_half_nxt  = 1'b0;
         end
         ADDR, CHAR: if (w_tick) begin
            w_phase_nxt = w_last_ph ? 2'd0 : r_phase + 2'd1;
            if (w_last_ph) begin
               w_half_nxt = ~r_half;
               if (r_half && r_state == ADDR) begin
                  w_state_nxt = CHAR;
                  w_idx_nxt   = 4'd0;
               end else if (r_half) begin
                  if (r_idx == 4'(CHARS - 1)) begin
                     w_idx_nxt = 4'd0;
                     if (r_ch == 2'(NUM_CH - 1)) begin
                        w_state_nxt = DONE;
                     end else begin
                        w_ch_nxt    = r_ch + 2'd1;
                        w_state_nxt = ADDR;
                     end
                  end else begin
                     w_idx_nxt = r_idx + 4'd1;
                  end
               end
            end
         end
         DONE: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            w_ch_nxt    = 2'd0;
         end
         default: w_state_nxt = PWRUP;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= PWRUP;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_phase <= '0;
         r_half  <= 1'b0;
         r_ch    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_idx   <= w_idx_nxt;
         r_phase <= w_phase_nxt;
         r_half  <= w_half_nxt;
         r_ch    <= w_ch_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_min  <= '0;
         r_seg  <= '0;
`ifdef LCD_ACTIVE_MARK_EN
         r_act  <= '0;
`endif
         r_last <= '0;
      end else begin
         if (r_state == SNAP) begin
            r_min <= min_flat;
            r_seg <= seg_flat;
`ifdef LCD_ACTIVE_MARK_EN
            r_act <= active;
`endif
         end
         if (w_xfer) r_last <= {w_rs, w_nib};
      end
   end

   always_comb begin
      lcd        = w_xfer ? {(r_phase == 2'd1), w_rs, w_nib} : {1'b0, r_last};
      busy       = (r_state != IDLE) && (r_state != DONE);
      frame_done = (r_state == DONE);
   end

endmodule

// File: tb/tb_lcd_clock_mux.sv
// Bench for lcd_clock_mux: a bus monitor decodes E strobes into nibbles, which are compared
// against frames built from the driven clock values with plain div/mod arithmetic.
`timescale 1ns/1ps
module tb_lcd_clock_mux;
   localparam int NCH = 4, TW = 6, DV = 2, PW = 3, RF = 6;
`ifdef LCD_ACTIVE_MARK_EN
   localparam int BPC = 7;
`else
   localparam int BPC = 6;
`endif
   localparam int FB  = NCH * BPC;
   localparam int LIM = 1000;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NCH*TW-1:0] min_flat = '0;
   logic [NCH*TW-1:0] seg_flat = '0;
   logic [5:0]        lcd;
   logic              busy, frame_done;
`ifdef LCD_ACTIVE_MARK_EN
   logic [NCH-1:0]    active = '0;
   logic [NCH-1:0]    tact;
`endif

   int checks = 0, failures = 0;
   int tmin[NCH], tseg[NCH];

   typedef struct packed {logic [4:0] v; logic ok;} nib_t;
   nib_t       nq[$];
   int         fdw_q[$], fdg_q[$], bl_q[$];
   logic [8:0] exp_fr[FB];
   logic [8:0] got_fr[FB];

   lcd_clock_mux #(.NUM_CH(NCH), .TIME_W(TW), .DIV(DV), .PWRUP_TICKS(PW), .REFRESH_TICKS(RF)) dut (
      .clk(clk), .rst(rst), .min_flat(min_flat), .seg_flat(seg_flat),
`ifdef LCD_ACTIVE_MARK_EN
      .active(active),
`endif
      .lcd(lcd), .busy(busy), .frame_done(frame_done));

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   // Bus monitor: one entry per E pulse, ok = E high exactly DV clks with RS/data steady around it.
   logic [5:0] m_prev = '0;
   logic [4:0] m_cur = '0;
   logic       m_in_e = 1'b0, m_stab = 1'b0, m_fd_on = 1'b0, m_pbusy = 1'b1, m_bvalid = 1'b0;
   int         cyc = 0, m_elen = 0, m_fall = 0, m_fdw = 0, m_fdg = 0, m_bstart = 0;

   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         m_in_e = 1'b0; m_fd_on = 1'b0; m_pbusy = 1'b1; m_bvalid = 1'b0; m_prev = lcd;
      end else begin
         if (lcd[5] && !m_prev[5]) begin
            m_in_e = 1'b1; m_cur = lcd[4:0]; m_elen = 1; m_stab = (m_prev[4:0] == lcd[4:0]);
         end else if (lcd[5] && m_in_e) begin
            m_elen++;
            if (lcd[4:0] != m_cur) m_stab = 1'b0;
         end else if (!lcd[5] && m_prev[5] && m_in_e) begin
            if (lcd[4:0] != m_cur) m_stab = 1'b0;
            nq.push_back('{v: m_cur, ok: (m_elen == DV) && m_stab});
            m_in_e = 1'b0;
            m_fall = cyc;
         end
         if (frame_done && !m_fd_on) begin
            m_fd_on = 1'b1; m_fdw = 1; m_fdg = cyc - m_fall;
         end else if (frame_done) begin
            m_fdw++;
         end else if (m_fd_on) begin
            fdw_q.push_back(m_fdw); fdg_q.push_back(m_fdg); m_fd_on = 1'b0;
         end
         if (busy && !m_pbusy) begin
            m_bstart = cyc; m_bvalid = 1'b1;
         end else if (!busy && m_pbusy && m_bvalid) begin
            bl_q.push_back(cyc - m_bstart); m_bvalid = 1'b0;
         end
         m_prev  = lcd;
         m_pbusy = busy;
      end
   end

   task automatic drive_inputs();
      for (int k = 0; k < NCH; k++) begin
         min_flat[k*TW +: TW] = TW'(tmin[k]);
         seg_flat[k*TW +: TW] = TW'(tseg[k]);
      end
`ifdef LCD_ACTIVE_MARK_EN
      active = tact;
`endif
   endtask

   task automatic randomize_inputs();
      for (int k = 0; k < NCH; k++) begin
         tmin[k] = int'($urandom_range(63, 0));
         tseg[k] = int'($urandom_range(63, 0));
      end
`ifdef LCD_ACTIVE_MARK_EN
      tact = NCH'($urandom);
`endif
   endtask

   // Reference frame: per channel, cursor command then the displayed characters.
   task automatic build_exp();
      for (int k = 0; k < NCH; k++) begin
         int b;
         b = k * BPC;
         exp_fr[b] = {1'b0, 8'(128 + (k % 2) * 64 + (k / 2) * 8)}; b++;
`ifdef LCD_ACTIVE_MARK_EN
         exp_fr[b] = {1'b1, tact[k] ? 8'h2A : 8'h20}; b++;
`endif
         exp_fr[b] = {1'b1, 8'(48 + tmin[k] / 10)}; b++;
         exp_fr[b] = {1'b1, 8'(48 + tmin[k] % 10)}; b++;
         exp_fr[b] = {1'b1, 8'h3A}; b++;
         exp_fr[b] = {1'b1, 8'(48 + tseg[k] / 10)}; b++;
         exp_fr[b] = {1'b1, 8'(48 + tseg[k] % 10)};
      end
   endtask

   task automatic get_nib(output nib_t n, output bit tmo);
      int w = 0;
      while (nq.size() == 0 && w < LIM) begin @(negedge clk); w++; end
      if (nq.size() == 0) begin n = '0; tmo = 1'b1; end
      else begin n = nq.pop_front(); tmo = 1'b0; end
   endtask

   task automatic get_frame(output int tbad, output int tmo);
      nib_t h, l;
      bit   th, tl;
      tbad = 0; tmo = 0;
      for (int b = 0; b < FB; b++) begin
         get_nib(h, th);
         get_nib(l, tl);
         got_fr[b] = {h.v[4], h.v[3:0], l.v[3:0]};
         if (th || tl) tmo++;
         if (!h.ok || !l.ok || h.v[4] != l.v[4]) tbad++;
      end
   endtask

   task automatic wait_fd(output int wd, output int gp, output bit tmo);
      int w = 0;
      while (fdw_q.size() == 0 && w < LIM) begin @(negedge clk); w++; end
      if (fdw_q.size() == 0) begin wd = -1; gp = -1; tmo = 1'b1; end
      else begin wd = fdw_q.pop_front(); gp = fdg_q.pop_front(); tmo = 1'b0; end
   endtask

   task automatic wait_bl(output int len);
      int w = 0;
      while (bl_q.size() == 0 && w < LIM) begin @(negedge clk); w++; end
      len = (bl_q.size() == 0) ? -1 : bl_q.pop_front();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      randomize_inputs();
      tmin[0] = 12; tseg[0] = 5; tmin[1] = 59; tseg[1] = 63;
`ifdef LCD_ACTIVE_MARK_EN
      tact = 4'b0010;
`endif
      drive_inputs();
      repeat (3) @(negedge clk);
      checks++; if (lcd !== 6'h00) begin failures++; $display("FAIL reset_lcd got=%h exp=00", lcd); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL reset_busy got=%b exp=1", busy); end
      checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
   endtask

   task automatic test_powerup();
      int nz = 0;
      nq.delete(); fdw_q.delete(); fdg_q.delete(); bl_q.delete();
      @(negedge clk) rst = 1'b0;
      for (int i = 0; i < PW * DV - 1; i++) begin
         @(negedge clk);
         if (lcd !== 6'h00) nz++;
      end
      checks++; if (nz != 0) begin failures++; $display("FAIL pwrup_quiet nonzero_samples=%0d exp=0", nz); end
      @(negedge clk);
      checks++; if (lcd !== 6'h03) begin failures++; $display("FAIL pwrup_first_nibble got=%h exp=03", lcd); end
   endtask

   task automatic test_init();
      logic [3:0] inib[12] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'hC, 4'h0, 4'h6, 4'h0, 4'h1};
      nib_t n;
      bit   t;
      int   nt = 0, nb = 0;
      for (int i = 0; i < 12; i++) begin
         get_nib(n, t);
         if (t) nt++;
         if (!n.ok) nb++;
         checks++;
         if (n.v !== {1'b0, inib[i]}) begin
            failures++; $display("FAIL init_nibble%0d got=%h exp=%h", i, n.v, {1'b0, inib[i]});
         end
      end
      checks++; if (nt != 0) begin failures++; $display("FAIL init_timeout got=%0d exp=0", nt); end
      checks++; if (nb != 0) begin failures++; $display("FAIL init_strobe_timing bad=%0d exp=0", nb); end
   endtask

   task automatic test_frame();
      int tb, tm, wd, gp;
      bit ft;
      build_exp();
      get_frame(tb, tm);
      for (int b = 0; b < FB; b++) begin
         checks++;
         if (got_fr[b] !== exp_fr[b]) begin
            failures++; $display("FAIL frame1_byte%0d got=%h exp=%h", b, got_fr[b], exp_fr[b]);
         end
      end
      checks++; if (tm != 0) begin failures++; $display("FAIL frame1_timeout got=%0d exp=0", tm); end
      checks++; if (tb != 0) begin failures++; $display("FAIL frame1_strobe_timing bad=%0d exp=0", tb); end
      wait_fd(wd, gp, ft);
      checks++; if (ft || wd != 1) begin failures++; $display("FAIL frame_done_width got=%0d exp=1", wd); end
      checks++; if (gp != DV) begin failures++; $display("FAIL frame_done_gap got=%0d exp=%0d", gp, DV); end
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b exp=0", busy); end
      checks++;
      if (lcd !== {2'b01, exp_fr[FB-1][3:0]}) begin
         failures++; $display("FAIL idle_hold got=%h exp=%h", lcd, {2'b01, exp_fr[FB-1][3:0]});
      end
   endtask

   task automatic test_snapshot();
      int tb, tm, wd, gp, bl, w;
      bit ft;
      build_exp();
      w = 0;
      while (nq.size() < 4 && w < 4 * LIM) begin @(negedge clk); w++; end
      checks++; if (nq.size() < 4) begin failures++; $display("FAIL snap_wait nibbles=%0d exp>=4", nq.size()); end
      tmin[0] = 0; tseg[0] = 0;
      drive_inputs();
      for (int f = 0; f < 2; f++) begin
         get_frame(tb, tm);
         for (int b = 0; b < FB; b++) begin
            checks++;
            if (got_fr[b] !== exp_fr[b]) begin
               failures++; $display("FAIL snap_frame%0d_byte%0d got=%h exp=%h", f, b, got_fr[b], exp_fr[b]);
            end
         end
         checks++; if (tm != 0 || tb != 0) begin failures++; $display("FAIL snap_frame%0d_stream timeouts=%0d bad=%0d exp=0", f, tm, tb); end
         wait_fd(wd, gp, ft);
         wait_bl(bl);
         checks++; if (bl != FB * 6 * DV) begin failures++; $display("FAIL snap_frame%0d_busy_len got=%0d exp=%0d", f, bl, FB * 6 * DV); end
         build_exp();
      end
   endtask

   task automatic test_back_to_back();
      int tb, tm, wd, gp, bl;
      bit ft;
      for (int f = 0; f < 3; f++) begin
         randomize_inputs();
         drive_inputs();
         build_exp();
         get_frame(tb, tm);
         for (int b = 0; b < FB; b++) begin
            checks++;
            if (got_fr[b] !== exp_fr[b]) begin
               failures++; $display("FAIL b2b_frame%0d_byte%0d got=%h exp=%h", f, b, got_fr[b], exp_fr[b]);
            end
         end
         checks++; if (tm != 0 || tb != 0) begin failures++; $display("FAIL b2b_frame%0d_stream timeouts=%0d bad=%0d exp=0", f, tm, tb); end
         wait_fd(wd, gp, ft);
         checks++; if (ft || wd != 1) begin failures++; $display("FAIL b2b_frame%0d_done_width got=%0d exp=1", f, wd); end
         wait_bl(bl);
         checks++; if (bl != FB * 6 * DV) begin failures++; $display("FAIL b2b_frame%0d_busy_len got=%0d exp=%0d", f, bl, FB * 6 * DV); end
      end
   endtask

   task automatic test_reset_midframe();
      int w = 0;
      while (!(nq.size() >= 6 && lcd[5] === 1'b1) && w < 4 * LIM) begin @(negedge clk); w++; end
      checks++; if (lcd[5] !== 1'b1) begin failures++; $display("FAIL midframe_find_e got=%b exp=1", lcd[5]); end
      #1 rst = 1'b1;
      #1;
      checks++; if (lcd !== 6'h00) begin failures++; $display("FAIL midframe_lcd got=%h exp=00", lcd); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midframe_busy got=%b exp=1", busy); end
      checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL midframe_frame_done got=%b exp=0", frame_done); end
      repeat (3) @(negedge clk);
      test_powerup();
      test_init();
   endtask

   initial begin
      test_reset();
      test_powerup();
      test_init();
      test_frame();
      test_snapshot();
      test_back_to_back();
      test_reset_midframe();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
